// File: rtl/ubi_sequencer.sv
// ---------------------------------------------------------------------------
// ubi_sequencer
//
// Runs the two UBI passes of one Skein-512 hash: first the message block,
// then the output block. Each pass launches the external Threefish core once
// and chains the result (ciphertext XOR plaintext) into the next key. After
// the output pass, the chained value is presented as the final hash.
//
// Ports
//   clk_i         clock; all state updates on the rising edge
//   rst_n_i       asynchronous active-low reset
//   start_i       request a new hash; taken only while ready_o=1
//   ready_o       high while idle
//   iv_i          initial chaining value, sampled when start_i is taken
//   msg_i         message block, sampled when start_i is taken
//   mode_o        tweak selector control: 0 message tweak, 1 output tweak
//   tweak_i       tweak returned by the selector (combinational on mode_o)
//   tf_start_o    one-cycle launch pulse to the Threefish core
//   tf_key_o      key to the core
//   tf_plain_o    plaintext to the core
//   tf_tweak_o    tweak to the core (tweak_i passed straight through)
//   tf_done_i     core result valid, one-cycle pulse
//   tf_cipher_i   core ciphertext, valid with tf_done_i
//   hash_o        final hash; holds until the next result
//   hash_valid_o  one-cycle pulse when hash_o updates
// ---------------------------------------------------------------------------
module ubi_sequencer #(
  parameter int STATE_W = 512,
  parameter int TWEAK_W = 192
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  output logic               ready_o,
  input  logic [STATE_W-1:0] iv_i,
  input  logic [STATE_W-1:0] msg_i,
  output logic               mode_o,
  input  logic [TWEAK_W-1:0] tweak_i,
  output logic               tf_start_o,
  output logic [STATE_W-1:0] tf_key_o,
  output logic [STATE_W-1:0] tf_plain_o,
  output logic [TWEAK_W-1:0] tf_tweak_o,
  input  logic               tf_done_i,
  input  logic [STATE_W-1:0] tf_cipher_i,
  output logic [STATE_W-1:0] hash_o,
  output logic               hash_valid_o
);

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = (STATE_W + WORD_W - 1) / WORD_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MSG_GO   = 3'd1,
    MSG_WAIT = 3'd2,
    OUT_GO   = 3'd3,
    OUT_WAIT = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state_reg, state_next;
  logic [STATE_W-1:0] key_reg, key_next;
  logic [STATE_W-1:0] plain_reg, plain_next;
  logic [STATE_W-1:0] hash_reg, hash_next;
  logic               mode_reg, mode_next;
  logic               tf_start_reg, tf_start_next;
  logic               hash_valid_reg, hash_valid_next;
  logic [STATE_W-1:0] chain_value;

  // UBI chaining: ciphertext XOR the plaintext of the pass just completed.
  // Split into 64-bit lanes; the last lane absorbs any width remainder.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_chain
      localparam int LO = gi * WORD_W;
      localparam int LW = ((STATE_W - LO) < WORD_W) ? (STATE_W - LO) : WORD_W;
      assign chain_value[LO +: LW] = tf_cipher_i[LO +: LW] ^ plain_reg[LO +: LW];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      key_reg        <= '0;
      plain_reg      <= '0;
      hash_reg       <= '0;
      mode_reg       <= 1'b0;
      tf_start_reg   <= 1'b0;
      hash_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      key_reg        <= key_next;
      plain_reg      <= plain_next;
      hash_reg       <= hash_next;
      mode_reg       <= mode_next;
      tf_start_reg   <= tf_start_next;
      hash_valid_reg <= hash_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    plain_next = plain_reg;
    hash_next  = hash_reg;
    mode_next  = mode_reg;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          key_next   = iv_i;
          plain_next = msg_i;
          mode_next  = 1'b0;
          state_next = MSG_GO;
        end
      end
      // A done pulse coinciding with the launch cannot belong to this
      // launch, so GO states never look at tf_done_i.
      MSG_GO: state_next = MSG_WAIT;
      MSG_WAIT: begin
        if (tf_done_i) begin
          key_next   = chain_value;
          plain_next = '0;           // output block: counter value 0
          mode_next  = 1'b1;         // selector settles before OUT_GO launch
          state_next = OUT_GO;
        end
      end
      OUT_GO: state_next = OUT_WAIT;
      OUT_WAIT: begin
        if (tf_done_i) begin
          hash_next  = chain_value;
          state_next = DONE;
        end
      end
      DONE: begin
        mode_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Pulse outputs are registered so they line up exactly with the state
    // they belong to.
    tf_start_next   = (state_next == MSG_GO) || (state_next == OUT_GO);
    hash_valid_next = (state_next == DONE);
  end

  assign ready_o      = (state_reg == IDLE);
  assign mode_o       = mode_reg;
  assign tf_start_o   = tf_start_reg;
  assign tf_key_o     = key_reg;
  assign tf_plain_o   = plain_reg;
  assign tf_tweak_o   = tweak_i;
  assign hash_o       = hash_reg;
  assign hash_valid_o = hash_valid_reg;

endmodule

// File: tb/tb_ubi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ubi_sequencer
//
// Drives ubi_sequencer with a stub Threefish core (done a fixed number of
// cycles after launch, cipher = key + 1) and a stub tweak selector. Expected
// hashes come from the UBI rule applied directly: hash = ((iv+1) ^ msg) + 1.
// ---------------------------------------------------------------------------
module tb_ubi_sequencer;

  localparam int SW = 512;
  localparam int TW = 192;

  localparam logic [63:0] MSG_T0 = 64'd64;
  localparam logic [63:0] MSG_T1 = 64'hF000000000000000;
  localparam logic [63:0] OUT_T0 = 64'd8;
  localparam logic [63:0] OUT_T1 = 64'hFF00000000000000;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          ready_o;
  logic [SW-1:0] iv_i;
  logic [SW-1:0] msg_i;
  logic          mode_o;
  logic [TW-1:0] tweak_i;
  logic          tf_start_o;
  logic [SW-1:0] tf_key_o;
  logic [SW-1:0] tf_plain_o;
  logic [TW-1:0] tf_tweak_o;
  logic          tf_done_i;
  logic [SW-1:0] tf_cipher_i;
  logic [SW-1:0] hash_o;
  logic          hash_valid_o;

  ubi_sequencer #(.STATE_W(SW), .TWEAK_W(TW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start_i),
    .ready_o      (ready_o),
    .iv_i         (iv_i),
    .msg_i        (msg_i),
    .mode_o       (mode_o),
    .tweak_i      (tweak_i),
    .tf_start_o   (tf_start_o),
    .tf_key_o     (tf_key_o),
    .tf_plain_o   (tf_plain_o),
    .tf_tweak_o   (tf_tweak_o),
    .tf_done_i    (tf_done_i),
    .tf_cipher_i  (tf_cipher_i),
    .hash_o       (hash_o),
    .hash_valid_o (hash_valid_o)
  );

  // Stub tweak selector, combinational on mode_o.
  assign tweak_i = mode_o ? {OUT_T0 ^ OUT_T1, OUT_T1, OUT_T0}
                          : {MSG_T0 ^ MSG_T1, MSG_T1, MSG_T0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          stub_cnt = 0;
  int          stub_lat = 3;
  logic [SW-1:0] stub_key = '0;

  int            lc_q[$];
  logic [SW-1:0] lk_q[$];
  logic [SW-1:0] lp_q[$];
  logic          lm_q[$];
  logic [TW-1:0] lt_q[$];
  int            hc_q[$];
  logic [SW-1:0] hh_q[$];

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rnd512();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_q();
    lc_q.delete(); lk_q.delete(); lp_q.delete(); lm_q.delete(); lt_q.delete();
    hc_q.delete(); hh_q.delete();
  endtask

  // Advance one cycle, sample #1 after the edge, run the stub core, log events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    tf_done_i = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        tf_done_i   = 1'b1;
        tf_cipher_i = stub_key + 512'd1;
      end
    end
    if (tf_start_o) begin
      stub_cnt = stub_lat;
      stub_key = tf_key_o;
      lc_q.push_back(cyc);
      lk_q.push_back(tf_key_o);
      lp_q.push_back(tf_plain_o);
      lm_q.push_back(mode_o);
      lt_q.push_back(tf_tweak_o);
    end
    if (hash_valid_o) begin
      hc_q.push_back(cyc);
      hh_q.push_back(hash_o);
    end
  endtask

  // One complete hash, called in an idle cycle. noise: a start_i pulse with
  // different data mid-operation. spur_go: a tf_done_i pulse during MSG_GO.
  task automatic run_hash(input string tag, input logic [SW-1:0] iv, input logic [SW-1:0] msg,
                          input int lat, input bit noise, input bit spur_go);
    logic [SW-1:0] k1;
    clear_q();
    stub_lat = lat;
    iv_i = iv; msg_i = msg; start_i = 1'b1;
    cyc = 0;
    tick();
    start_i = 1'b0;
    if (spur_go) begin
      tf_done_i   = 1'b1;
      tf_cipher_i = rnd512();
    end
    for (int i = 0; i < 80 && hc_q.size() == 0; i++) begin
      tick();
      start_i = noise && (cyc == 3);
      if (noise && cyc == 3) begin
        iv_i  = ~iv;
        msg_i = ~msg;
      end
    end
    start_i = 1'b0;
    tick();
    chk_int({tag, "_ready_back"}, int'(ready_o), 1);
    chk_int({tag, "_hv_low_after"}, int'(hash_valid_o), 0);
    tick();
    tick();
    k1 = (iv + 512'd1) ^ msg;
    chk_int({tag, "_launches"}, lc_q.size(), 2);
    chk_int({tag, "_launch0_cyc"}, lc_q[0], 1);
    chk_int({tag, "_launch1_cyc"}, lc_q[1], 2 + lat);
    chk({tag, "_key0"}, lk_q[0], iv);
    chk({tag, "_plain0"}, lp_q[0], msg);
    chk({tag, "_key1"}, lk_q[1], k1);
    chk({tag, "_plain1"}, lp_q[1], '0);
    chk_int({tag, "_mode0"}, int'(lm_q[0]), 0);
    chk_int({tag, "_mode1"}, int'(lm_q[1]), 1);
    chk_int({tag, "_hv_count"}, hc_q.size(), 1);
    chk_int({tag, "_hv_cyc"}, hc_q[0], 3 + 2 * lat);
    chk({tag, "_hash"}, hh_q[0], k1 + 512'd1);
    chk({tag, "_hash_hold"}, hash_o, k1 + 512'd1);
    $display("txn %s lat=%0d hash=%0h", tag, lat, hh_q[0]);
  endtask

  initial begin
    logic [TW-1:0] tw;
    logic [SW-1:0] kept_key, kept_hash, riv, rmsg;

    rst_n = 1'b0; start_i = 1'b0; iv_i = '0; msg_i = '0;
    tf_done_i = 1'b0; tf_cipher_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("rst_ready", int'(ready_o), 1);
    chk_int("rst_mode", int'(mode_o), 0);
    chk_int("rst_tf_start", int'(tf_start_o), 0);
    chk_int("rst_hash_valid", int'(hash_valid_o), 0);
    chk("rst_hash", hash_o, '0);
    chk("rst_key", tf_key_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("txn reset released");

    // T1 + T2: zero IV and message, latency 3.
    run_hash("t1", '0, '0, 3, 1'b0, 1'b0);
    chk_int("t1_hv_cycle9", hc_q[0], 9);
    chk("t1_hash2", hh_q[0], 512'd2);
    tw = lt_q[0];
    chk("t2_tw0_t0", 512'(tw[63:0]), 512'(MSG_T0));
    chk("t2_tw0_t1", 512'(tw[127:64]), 512'(MSG_T1));
    tw = lt_q[1];
    chk("t2_tw1_t0", 512'(tw[63:0]), 512'(OUT_T0));

    // T3: iv=5, msg=3, with a start_i pulse of other data mid-run.
    run_hash("t3", 512'd5, 512'd3, 3, 1'b1, 1'b0);
    chk("t3_key1_is5", lk_q[1], 512'd5);
    chk("t3_hash6", hh_q[0], 512'd6);

    // T6a: spurious done while idle.
    clear_q();
    kept_key  = tf_key_o;
    kept_hash = hash_o;
    tf_done_i   = 1'b1;
    tf_cipher_i = rnd512();
    tick();
    tick();
    chk_int("t6_idle_ready", int'(ready_o), 1);
    chk("t6_idle_key", tf_key_o, kept_key);
    chk("t6_idle_hash", hash_o, kept_hash);
    chk_int("t6_idle_no_hv", hc_q.size(), 0);
    chk_int("t6_idle_no_launch", lc_q.size(), 0);
    $display("txn spurious done in idle");

    // T6b: spurious done during MSG_GO must not cut the first pass short.
    run_hash("t6go", 512'd5, 512'd3, 3, 1'b0, 1'b1);

    // T4: start_i held 20 cycles gives exactly two back-to-back hashes.
    clear_q();
    stub_lat = 3;
    iv_i = '0; msg_i = '0; start_i = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) tick();
    start_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk_int("t4_hv_count", hc_q.size(), 2);
    chk_int("t4_hv0_cyc", hc_q[0], 9);
    chk_int("t4_hv1_cyc", hc_q[1], 19);
    chk("t4_hash0", hh_q[0], 512'd2);
    chk("t4_hash1", hh_q[1], 512'd2);
    chk_int("t4_launches", lc_q.size(), 4);
    chk_int("t4_launch1_cyc", lc_q[1], 5);
    chk_int("t4_launch2_cyc", lc_q[2], 11);
    $display("txn held start: hashes=%0d", hc_q.size());

    // Randomised data and core latency against the UBI rule.
    for (int n = 0; n < 6; n++) begin
      riv  = rnd512();
      rmsg = rnd512();
      run_hash($sformatf("rnd%0d", n), riv, rmsg, int'($urandom_range(1, 6)),
               1'(n % 2), 1'(n == 3));
    end

    // T5: reset during MSG_WAIT; the stub's pending done arrives afterwards.
    clear_q();
    stub_lat = 3;
    iv_i = rnd512(); msg_i = rnd512(); start_i = 1'b1;
    cyc = 0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #2;
    chk_int("t5_async_ready", int'(ready_o), 1);
    chk("t5_async_hash", hash_o, '0);
    chk_int("t5_async_mode", int'(mode_o), 0);
    chk_int("t5_async_tf_start", int'(tf_start_o), 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_int("t5_ready_after", int'(ready_o), 1);
    chk_int("t5_launches", lc_q.size(), 1);
    chk_int("t5_no_hv", hc_q.size(), 0);
    chk("t5_hash_zero", hash_o, '0);
    chk("t5_key_zero", tf_key_o, '0);
    $display("txn reset mid-operation");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
